serial_subtractor: RTL

Bit-serial N-bit subtractor computing `a - b` LSB-first over WIDTH clock cycles using a single full-subtractor cell and a registered borrow. It sits beside the combinational adder primitives as the area-cheap, sequential counterpart for subtraction. A start/busy/done handshake lets a controlling FSM or testbench launch an operation and collect the result.

---
 rtl/serial_subtractor.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH LSB-first,
// one bit per clock, with a single full-subtractor cell and a registered
// borrow. A start/busy/done handshake launches an operation and flags
// completion.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   When defined, an extra output ovf reports signed (two's complement)
//   overflow of the subtraction. When undefined, ovf and its logic are absent.
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst_n   in   1      synchronous active-low reset
//   start   in   1      launch request, honoured only while idle
//   a       in   WIDTH  minuend, captured on the accepting edge
//   b       in   WIDTH  subtrahend, captured on the accepting edge
//   busy    out  1      high while bits are being processed
//   done    out  1      one-cycle pulse when diff/borrow are fresh
//   diff    out  WIDTH  (a - b) mod 2^WIDTH, held until the next completion
//   borrow  out  1      final borrow-out, 1 iff a < b (unsigned)
//   ovf     out  1      signed overflow (only with SERIAL_SUB_OVF_EN)
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic [WIDTH-1:0] res_next;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             ai, bi, d, br_next;
   logic             last_bit;

`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb, b_msb;
`endif

   // Full-subtractor cell on the current operand LSBs.
   assign ai       = a_sr[0];
   assign bi       = b_sr[0];
   assign d        = ai ^ bi ^ br;
   assign br_next  = (~ai & bi) | (~(ai ^ bi) & br);
   assign last_bit = (cnt == CW'(WIDTH - 1));

   // Result bits enter from the MSB side so that after WIDTH shifts the
   // first (LSB) difference bit has reached position 0.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_next = d;
      end else begin : g_res_wn
         assign res_next = {d, res_sr[WIDTH-1:1]};
      end
   endgenerate

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   // NOTE: the shift registers are reset along with the control state; they
   // are small flop arrays, not RAM, and a known zero state keeps the
   // datapath free of X after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sr    <= '0;
         b_sr    <= '0;
         res_sr  <= '0;
         cnt     <= '0;
         br      <= 1'b0;
         diff    <= '0;
         borrow  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb   <= 1'b0;
         b_msb   <= 1'b0;
         ovf     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_sr <= a;
                  b_sr <= b;
                  br   <= 1'b0;
                  cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
`endif
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               br     <= br_next;
               cnt    <= cnt + 1'b1;
               if (last_bit) begin
                  diff   <= res_next;
                  borrow <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                  // d is the MSB of the completed difference.
                  ovf    <= (a_msb != b_msb) && (d != a_msb);
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule
